// File: rtl/gait_sequencer_if.sv
// Handshake bundle between the heartrate/switch side and the gait sequencer.
// The master drives tick/run/dir/rehome; the sequencer returns the ROM address and status.
interface gait_sequencer_if #(
    parameter int AW = 8
);
    logic          tick;
    logic          run;
    logic          dir;
    logic          rehome;
    logic [AW-1:0] addr;
    logic          homing;
    logic          walking;
    logic          cycle_done;
    logic [1:0]    state;

    modport master (
        output tick, run, dir, rehome,
        input  addr, homing, walking, cycle_done, state
    );

    modport slave (
        input  tick, run, dir, rehome,
        output addr, homing, walking, cycle_done, state
    );
endinterface

// File: rtl/gait_sequencer.sv
// Leg-position ROM address sequencer: holds HOME for HOME_TICKS heartrate ticks,
// then steps the address forward/backward per tick, parking only at step 0.
module gait_sequencer #(
    parameter int M          = 64,
    parameter int HOME_TICKS = 20,
    parameter int AW         = 8
) (
    input  logic              clk,
    input  logic              rst,
    gait_sequencer_if.slave   bus
);

    localparam int            HW    = $clog2(HOME_TICKS) + 1;
    localparam logic [AW-1:0] LAST  = AW'(M - 1);
    localparam logic [HW-1:0] HLAST = HW'(HOME_TICKS - 1);

    typedef enum logic [1:0] {
        S_HOME = 2'd0,
        S_IDLE = 2'd1,
        S_WALK = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          cycle_done_q, cycle_done_d;
    logic          homing_q, homing_d;
    logic          walking_q, walking_d;
    logic [AW-1:0] step_addr;

    always_comb begin
        step_addr = addr_q;
        if (bus.dir) begin
            step_addr = (addr_q == '0) ? LAST : addr_q - 1'b1;
        end else begin
            step_addr = (addr_q == LAST) ? '0 : addr_q + 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        hcnt_d       = hcnt_q;
        cycle_done_d = 1'b0;

        // rehome outranks every other input, including a tick in the same clk
        if (bus.rehome) begin
            state_d = S_HOME;
            addr_d  = '0;
            hcnt_d  = '0;
        end else begin
            case (state_q)
                S_HOME: begin
                    addr_d = '0;
                    if (bus.tick) begin
                        if (hcnt_q == HLAST) begin
                            hcnt_d  = '0;
                            state_d = bus.run ? S_WALK : S_IDLE;
                        end else begin
                            hcnt_d = hcnt_q + 1'b1;
                        end
                    end
                end
                S_IDLE: begin
                    addr_d = '0;
                    hcnt_d = '0;
                    if (bus.run) begin
                        state_d = S_WALK;
                    end
                end
                S_WALK: begin
                    if (bus.tick) begin
                        addr_d       = step_addr;
                        cycle_done_d = (step_addr == '0);
                        // a drained stop parks on the same edge that lands on step 0
                        if (!bus.run && step_addr == '0) begin
                            state_d = S_IDLE;
                        end
                    end else if (!bus.run && addr_q == '0) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_HOME;
                    addr_d  = '0;
                    hcnt_d  = '0;
                end
            endcase
        end

        homing_d  = (state_d == S_HOME);
        walking_d = (state_d == S_WALK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_HOME;
            addr_q       <= '0;
            hcnt_q       <= '0;
            cycle_done_q <= 1'b0;
            homing_q     <= 1'b1;
            walking_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            hcnt_q       <= hcnt_d;
            cycle_done_q <= cycle_done_d;
            homing_q     <= homing_d;
            walking_q    <= walking_d;
        end
    end

    assign bus.addr       = addr_q;
    assign bus.homing     = homing_q;
    assign bus.walking    = walking_q;
    assign bus.cycle_done = cycle_done_q;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_gait_sequencer.sv
// Directed bench for gait_sequencer with M=8, HOME_TICKS=4: a vector table for
// the walking sequence plus hand sequences for reset, held rehome and idle start.
module tb_gait_sequencer;

    localparam int M  = 8;
    localparam int HT = 4;
    localparam int AW = 8;
    localparam logic [1:0] H = 2'd0, I = 2'd1, W = 2'd2, X = 2'd3;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    gait_sequencer_if #(.AW(AW)) bus ();

    gait_sequencer #(.M(M), .HOME_TICKS(HT), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       tick;
        logic       run;
        logic       dir;
        logic       rehome;
        logic [7:0] addr;
        logic [1:0] st;
        logic       cd;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic t, input logic r, input logic d, input logic h,
                       input int a, input logic [1:0] s, input logic c);
        vec_t v;
        v.tick = t; v.run = r; v.dir = d; v.rehome = h;
        v.addr = 8'(a); v.st = s; v.cd = c;
        tbl.push_back(v);
    endtask

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // st==X leaves state/homing/walking unchecked for that vector
    task automatic chk(input string nm, input logic [7:0] ea, input logic [1:0] es, input logic ec);
        cmp({nm, ".addr"}, int'(bus.addr), int'(ea));
        cmp({nm, ".cycle_done"}, int'(bus.cycle_done), int'(ec));
        if (es != X) begin
            cmp({nm, ".state"}, int'(bus.state), int'(es));
            cmp({nm, ".homing"}, int'(bus.homing), int'(es == H));
            cmp({nm, ".walking"}, int'(bus.walking), int'(es == W));
        end
    endtask

    task automatic apply(input logic t, input logic r, input logic d, input logic h);
        bus.tick = t; bus.run = r; bus.dir = d; bus.rehome = h;
        @(posedge clk);
        #1;
        bus.tick = 1'b0; bus.rehome = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.tick = 1'b0; bus.rehome = 1'b0;
        @(posedge clk);
        #1;
        chk("reset", 8'd0, H, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.tick = 1'b0; bus.run = 1'b1; bus.dir = 1'b0; bus.rehome = 1'b0;

        // startup: 4 ticks in HOME, then one full forward gait cycle
        for (int k = 0; k < 3; k++) add(1, 1, 0, 0, 0, H, 0);
        add(1, 1, 0, 0, 0, W, 0);
        for (int k = 1; k < 8; k++) add(1, 1, 0, 0, k, W, 0);
        add(1, 1, 0, 0, 0, W, 1);
        add(0, 1, 0, 0, 0, W, 0);
        // walk to 5, drop run, drain to 0 and park
        for (int k = 1; k < 6; k++) add(1, 1, 0, 0, k, W, 0);
        add(1, 0, 0, 0, 6, W, 0);
        add(1, 0, 0, 0, 7, W, 0);
        add(1, 0, 0, 0, 0, X, 1);
        add(0, 0, 0, 0, 0, I, 0);
        add(1, 0, 0, 0, 0, I, 0);
        add(0, 1, 0, 0, 0, W, 0);
        // reverse from 0 wraps to M-1 with no cycle_done
        add(1, 1, 1, 0, 7, W, 0);
        add(1, 1, 0, 0, 0, W, 1);
        add(1, 1, 0, 0, 1, W, 0);
        add(1, 1, 0, 0, 2, W, 0);
        // dir=1 at 2: 1,0,7,6 then dir=0 gives 7
        add(1, 1, 1, 0, 1, W, 0);
        add(1, 1, 1, 0, 0, W, 1);
        add(1, 1, 1, 0, 7, W, 0);
        add(1, 1, 1, 0, 6, W, 0);
        add(1, 1, 0, 0, 7, W, 0);
        add(1, 1, 0, 0, 0, W, 1);
        add(1, 1, 0, 0, 1, W, 0);
        add(1, 1, 0, 0, 2, W, 0);
        add(1, 1, 0, 0, 3, W, 0);
        // rehome with a simultaneous tick: no step, 4 more ticks to leave HOME
        add(1, 1, 0, 1, 0, H, 0);
        for (int k = 0; k < 3; k++) add(1, 1, 0, 0, 0, H, 0);
        add(1, 1, 0, 0, 0, W, 0);
        // run dropped then restored mid-drain cancels the stop
        add(1, 0, 0, 0, 1, W, 0);
        add(0, 1, 0, 0, 1, W, 0);
        add(1, 1, 0, 0, 2, W, 0);
        add(0, 1, 0, 1, 0, H, 0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset_init", 8'd0, H, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].tick, tbl[i].run, tbl[i].dir, tbl[i].rehome);
            chk($sformatf("v%0d", i), tbl[i].addr, tbl[i].st, tbl[i].cd);
        end

        // rehome held high pins hcnt at 0 despite ticks
        for (int k = 0; k < 3; k++) begin
            apply(1, 1, 0, 1);
            bus.rehome = 1'b1;
            chk($sformatf("hold_rehome%0d", k), 8'd0, H, 1'b0);
        end
        bus.rehome = 1'b0;
        for (int k = 0; k < 3; k++) begin
            apply(1, 1, 0, 0);
            chk($sformatf("after_hold%0d", k), 8'd0, H, 1'b0);
        end
        apply(1, 1, 0, 0);
        chk("after_hold_exit", 8'd0, W, 1'b0);

        // async reset mid-clk while at addr 6
        for (int k = 1; k < 7; k++) apply(1, 1, 0, 0);
        chk("pre_async", 8'd6, W, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst", 8'd0, H, 1'b0);
        #3 rst = 1'b0;

        // run=0 through HOME lands in IDLE; ticks ignored; run starts walking
        do_reset();
        for (int k = 0; k < 3; k++) begin
            apply(1, 0, 0, 0);
            chk($sformatf("idle_home%0d", k), 8'd0, H, 1'b0);
        end
        apply(1, 0, 0, 0);
        chk("idle_enter", 8'd0, I, 1'b0);
        for (int k = 0; k < 3; k++) begin
            apply(1, 0, 0, 0);
            chk($sformatf("idle_tick%0d", k), 8'd0, I, 1'b0);
        end
        apply(0, 1, 0, 0);
        chk("idle_run", 8'd0, W, 1'b0);
        apply(1, 1, 0, 0);
        chk("idle_first_step", 8'd1, W, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/gait_sequencer.md
Name: gait_sequencer

Overview:
Sequences the leg-position ROM address for the hexapod gait. It holds legs at the home pose for a fixed number of heartrate ticks after reset, then walks the ROM address forward or backward on each heartrate tick. It stops only at a gait-cycle boundary. It sits between heartrate_hz and the leg ROMs, replacing the free-running counter_8_bits as the ROM address source.

Parameters:
M, 64, steps per gait cycle; addr counts modulo M; legal range 2 <= M <= 2^AW
HOME_TICKS, 20, heartrate ticks spent in HOME before leaving it; legal range >= 1
AW, 8, address width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
tick  in  1  one-clk-wide pulse from heartrate_hz; the rhythm of the robot
run  in  1  level (SW1); 1 = walk, 0 = stop at next cycle boundary
dir  in  1  level; 0 = forward (addr increments), 1 = reverse (addr decrements)
rehome  in  1  one-clk pulse; forces return to HOME from any state
addr  out  AW  ROM address (registered)
homing  out  1  1 while in HOME
walking  out  1  1 while in WALK
cycle_done  out  1  one-clk pulse when a tick in WALK moves addr to 0
state  out  2  HOME=0, IDLE=1, WALK=2 (debug/LEDs)

Behaviour:
- Reset (async, rst=1) sets: state=HOME, addr=0, home counter hcnt=0, homing=1, walking=0, cycle_done=0.
- All outputs are registered. addr changes on the clk edge after the cycle in which tick=1 is sampled, giving 1-clk latency.
- HOME:
  - addr is held at 0.
  - Each tick increments hcnt.
  - On the tick where hcnt==HOME_TICKS-1: go to WALK if run=1, otherwise go to IDLE; clear hcnt.
  - Ticks received before that point do not move addr.
- IDLE:
  - addr is held (always 0 here).
  - run=1 moves to WALK on the next edge. Ticks are ignored until then.
- WALK, on each tick:
  - dir=0: addr = (addr==M-1) ? 0 : addr+1.
  - dir=1: addr = (addr==0) ? M-1 : addr-1.
  - If the new addr is 0, cycle_done pulses for exactly 1 clk, aligned with addr becoming 0.
- WALK stop rule:
  - If run=0 and addr==0 in a cycle with no tick, go to IDLE on the next edge.
  - If run=0 and addr!=0, keep stepping on ticks until addr reaches 0, then go to IDLE.
  - Result: the robot always parks at the neutral step 0.
- Entering WALK with addr=0 and dir=1: the first tick gives addr=M-1, with no cycle_done.
- A dir change mid-cycle takes effect on the next tick. No glitch on addr.
- A run toggle 0->1 while draining in WALK cancels the stop; walking continues.
- rehome=1 in any state, on the next edge: state=HOME, addr=0, hcnt=0, cycle_done=0.
  - rehome has priority over a simultaneous tick, run, or cycle_done.
  - rehome held high keeps the block in HOME with hcnt=0.
- Ticks on consecutive clks are each honoured (one step per tick). There is no tick buffering: a tick arriving in a state that ignores it is lost.
- hcnt width is clog2(HOME_TICKS)+1. It never exceeds HOME_TICKS-1.
- Unreachable state encoding (3) recovers to HOME on the next edge.

Test Plan:
All scenarios use M=8, HOME_TICKS=4.
- Reset release, run=1, dir=0, 4 ticks -> homing=1 and addr=0 throughout; after the 4th tick state=WALK and homing=0. The next 8 ticks give addr 1,2,...,7,0, with cycle_done high for exactly 1 clk with the last.
- Reset, run=0, 4 ticks -> state=IDLE, addr=0. Then 3 more ticks -> addr stays 0. Assert run -> WALK on the next edge.
- In WALK at addr=5, drop run -> ticks give addr 6,7,0, cycle_done pulses, then state=IDLE. A further tick leaves addr=0.
- In WALK at addr=2, set dir=1 -> ticks give 1,0 (cycle_done),7,6. Switch dir=0 at addr=6 -> next tick gives 7.
- In WALK at addr=3, pulse rehome in the same clk as a tick -> addr=0, state=HOME, hcnt=0, no step taken. 4 further ticks are required to leave HOME.
- Assert rst asynchronously mid-clk while addr=6 in WALK -> addr=0, state=HOME, homing=1 immediately, without waiting for a clk edge.
